// File: rtl/maze_arbiter.sv
// Round-robin arbiter that lends one shared maze solver to two requesters:
// streams the granted maze in, routes directions back, reports status per job.
module maze_arbiter #(
  parameter int N_BITS  = 289,
  parameter int TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       in_valid0,
  input  logic       in_valid1,
  input  logic       in0,
  input  logic       in1,
  output logic       m_in_valid,
  output logic       m_in,
  input  logic       m_out_valid,
  input  logic [1:0] m_out,
  output logic       out_valid0,
  output logic       out_valid1,
  output logic [1:0] out0,
  output logic [1:0] out1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [9:0] steps
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SOLVE, RELEASE} state_t;

  state_t        r_state, w_next;
  logic          r_sel, r_prio, r_err_pend, r_seen;
  logic [8:0]    r_bit_cnt;
  logic [9:0]    r_steps_cnt, r_steps;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_m_in_valid, r_m_in;
  logic          r_out_valid0, r_out_valid1;
  logic [1:0]    r_out0, r_out1;

  logic w_iv, w_ib, w_pick, w_last_bit, w_timeout, w_solve_dir;

  assign w_iv        = r_sel ? in_valid1 : in_valid0;
  assign w_ib        = r_sel ? in1 : in0;
  // Tie goes to the pointer; a lone requester wins regardless of it.
  assign w_pick      = (req0 && req1) ? r_prio : req1;
  assign w_last_bit  = (r_state == LOAD) && w_iv && (r_bit_cnt == 9'(N_BITS - 1));
  assign w_timeout   = !r_seen && !m_out_valid && (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign w_solve_dir = (r_state == SOLVE) && m_out_valid;

  always_comb begin
    w_next = r_state;
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    done0  = 1'b0;
    done1  = 1'b0;
    err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 || req1) w_next = LOAD;
      end
      LOAD: begin
        gnt0 = !r_sel;
        gnt1 = r_sel;
        if (w_last_bit || (!w_iv && r_bit_cnt != '0)) w_next = SOLVE;
      end
      SOLVE: begin
        gnt0 = !r_sel;
        gnt1 = r_sel;
        if ((r_seen && !m_out_valid) || w_timeout) w_next = RELEASE;
      end
      RELEASE: begin
        done0  = !r_sel;
        done1  = r_sel;
        err    = r_err_pend;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_prio       <= 1'b0;
      r_err_pend   <= 1'b0;
      r_seen       <= 1'b0;
      r_bit_cnt    <= '0;
      r_steps_cnt  <= '0;
      r_steps      <= '0;
      r_tmo_cnt    <= '0;
      r_m_in_valid <= 1'b0;
      r_m_in       <= 1'b0;
      r_out_valid0 <= 1'b0;
      r_out_valid1 <= 1'b0;
      r_out0       <= '0;
      r_out1       <= '0;
    end else begin
      r_state      <= w_next;
      r_m_in_valid <= (r_state == LOAD) && w_iv;
      r_m_in       <= (r_state == LOAD) && w_iv && w_ib;
      r_out_valid0 <= w_solve_dir && !r_sel;
      r_out_valid1 <= w_solve_dir && r_sel;
      r_out0       <= (w_solve_dir && !r_sel) ? m_out : '0;
      r_out1       <= (w_solve_dir && r_sel) ? m_out : '0;
      case (r_state)
        IDLE: begin
          if (req0 || req1) r_sel <= w_pick;
        end
        LOAD: begin
          if (w_iv) r_bit_cnt <= r_bit_cnt + 9'd1;
          if (!w_iv && r_bit_cnt != '0) r_err_pend <= 1'b1;
        end
        SOLVE: begin
          // Bits still arriving after the maze is complete mark the job bad.
          if (w_iv) r_err_pend <= 1'b1;
          if (!r_seen) r_tmo_cnt <= r_tmo_cnt + TW'(1);
          if (m_out_valid) begin
            r_seen <= 1'b1;
            if (r_steps_cnt != '1) r_steps_cnt <= r_steps_cnt + 10'd1;
          end
          if (w_next == RELEASE) begin
            r_steps <= r_steps_cnt;
            if (!r_seen) r_err_pend <= 1'b1;
          end
        end
        RELEASE: begin
          r_prio      <= !r_sel;
          r_err_pend  <= 1'b0;
          r_seen      <= 1'b0;
          r_bit_cnt   <= '0;
          r_steps_cnt <= '0;
          r_tmo_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign m_in_valid = r_m_in_valid;
  assign m_in       = r_m_in;
  assign out_valid0 = r_out_valid0;
  assign out_valid1 = r_out_valid1;
  assign out0       = r_out0;
  assign out1       = r_out1;
  assign steps      = r_steps;

endmodule

// File: tb/tb_maze_arbiter.sv
// Randomized scoreboard bench for maze_arbiter: stimulus pushes expected
// grants, maze bits, directions and job status; a negedge monitor pops them.
module tb_maze_arbiter;

  localparam int NB = 289;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, gnt0, gnt1;
  logic       in_valid0, in_valid1, in0, in1;
  logic       m_in_valid, m_in, m_out_valid;
  logic [1:0] m_out, out0, out1;
  logic       out_valid0, out_valid1, done0, done1, err;
  logic [9:0] steps;

  maze_arbiter #(.N_BITS(NB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .in_valid0(in_valid0), .in_valid1(in_valid1), .in0(in0), .in1(in1),
    .m_in_valid(m_in_valid), .m_in(m_in), .m_out_valid(m_out_valid), .m_out(m_out),
    .out_valid0(out_valid0), .out_valid1(out_valid1), .out0(out0), .out1(out1),
    .done0(done0), .done1(done1), .err(err), .steps(steps)
  );

  always #5 clk = ~clk;

  typedef struct {
    int who;
    int err;
    int steps;
    bit lat;
  } done_t;

  done_t      q_done[$];
  int         q_gnt[$];
  bit         q_min[$];
  logic [1:0] q_out0[$];
  logic [1:0] q_out1[$];

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;
  int last_min_cyc = 0;
  int last_served = 1;
  bit prev_g = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: got DUT output expected none (t=%0t)", name, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      prev_g = 1'b0;
    end else begin
      cyc++;
      chk("gnt_exclusive", int'(gnt0 && gnt1), 0);
      if ((gnt0 || gnt1) && !prev_g) begin
        if (q_gnt.size() == 0) unexpected("gnt");
        else chk("gnt_winner", int'(gnt1), q_gnt.pop_front());
      end
      prev_g = gnt0 || gnt1;
      if (m_in_valid) begin
        last_min_cyc = cyc;
        if (q_min.size() == 0) unexpected("m_in");
        else chk("m_in_bit", int'(m_in), int'(q_min.pop_front()));
      end
      if (out_valid0) begin
        if (q_out0.size() == 0) unexpected("out0");
        else chk("out0_dir", int'(out0), int'(q_out0.pop_front()));
      end
      if (out_valid1) begin
        if (q_out1.size() == 0) unexpected("out1");
        else chk("out1_dir", int'(out1), int'(q_out1.pop_front()));
      end
      if (done0 || done1) begin
        done_t e;
        chk("done_exclusive", int'(done0 && done1), 0);
        if (q_done.size() == 0) unexpected("done");
        else begin
          e = q_done.pop_front();
          chk("done_who", int'(done1), e.who);
          chk("done_err", int'(err), e.err);
          chk("done_steps", int'(steps), e.steps);
          if (e.lat) chk("timeout_latency", cyc - last_min_cyc, TO);
        end
        n_done++;
      end else begin
        chk("err_idle", int'(err), 0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, int'({gnt0, gnt1}), 0);
    chk({tag, "_m_in"}, int'({m_in_valid, m_in}), 0);
    chk({tag, "_outv"}, int'({out_valid0, out_valid1}), 0);
    chk({tag, "_outd"}, int'({out0, out1}), 0);
    chk({tag, "_done_err"}, int'({done0, done1, err}), 0);
    chk({tag, "_steps"}, int'(steps), 0);
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) begin
        ok = 1'b1;
        return;
      end
    end
    chk("gnt_timeout", 0, 1);
  endtask

  task automatic stream(input int w, input int nbits, input bit noise);
    bit b;
    for (int i = 0; i < nbits; i++) begin
      b = 1'($urandom_range(0, 1));
      if (w == 0) begin in_valid0 = 1'b1; in0 = b; end
      else        begin in_valid1 = 1'b1; in1 = b; end
      if (i < NB) q_min.push_back(b);
      if (noise) begin
        if (w == 0) begin in_valid1 = 1'($urandom_range(0, 1)); in1 = 1'($urandom_range(0, 1)); end
        else        begin in_valid0 = 1'($urandom_range(0, 1)); in0 = 1'($urandom_range(0, 1)); end
      end
      @(posedge clk); #1;
    end
    in_valid0 = 1'b0; in_valid1 = 1'b0; in0 = 1'b0; in1 = 1'b0;
  endtask

  task automatic emit(input int w, input int ndirs);
    for (int d = 0; d < ndirs; d++) begin
      m_out_valid = 1'b1;
      m_out = 2'($urandom_range(0, 3));
      if (w == 0) q_out0.push_back(m_out);
      else        q_out1.push_back(m_out);
      @(posedge clk); #1;
    end
    m_out_valid = 1'b0;
    m_out = '0;
  endtask

  // One job: reference model picks the winner and the final status from the rules.
  task automatic job(input bit r0, input bit r1, input int nbits, input int ndirs, input bit noise);
    int w, n0, e, s;
    bit ok;
    w = (r0 && r1) ? ((last_served == 0) ? 1 : 0) : (r0 ? 0 : 1);
    q_gnt.push_back(w);
    n0 = n_done;
    req0 = r0; req1 = r1;
    wait_gnt(ok);
    req0 = 1'b0; req1 = 1'b0;
    if (!ok) return;
    stream(w, nbits, noise);
    e = int'((nbits != NB) || (ndirs == 0));
    s = (ndirs > 1023) ? 1023 : ndirs;
    q_done.push_back('{who: w, err: e, steps: s, lat: (nbits == NB) && (ndirs == 0)});
    repeat ($urandom_range(2, 6)) @(posedge clk);
    #1;
    emit(w, ndirs);
    for (int k = 0; k < TO + 100; k++) begin
      if (n_done != n0) break;
      @(posedge clk); #1;
    end
    if (n_done == n0) chk("done_timeout", 0, 1);
    last_served = w;
  endtask

  task automatic reset_mid_solve();
    bit ok;
    q_gnt.push_back(0);
    req0 = 1'b1;
    wait_gnt(ok);
    req0 = 1'b0;
    stream(0, NB, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    emit(0, 5);
    m_out_valid = 1'b1;
    m_out = 2'd3;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    m_out_valid = 1'b0;
    m_out = '0;
    q_gnt.delete(); q_min.delete(); q_out0.delete(); q_out1.delete(); q_done.delete();
    last_served = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    rst = 1'b1;
    req0 = 0; req1 = 0; in_valid0 = 0; in_valid1 = 0; in0 = 0; in1 = 0;
    m_out_valid = 0; m_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    job(1, 1, NB, 10, 0);          // tie from reset -> 0
    job(1, 1, NB, 8, 0);           // tie -> 1
    job(1, 1, NB, 6, 0);           // tie -> 0
    job(1, 0, NB, 40, 0);          // basic job, steps=40
    job(1, 0, 100, 7, 0);          // short stream -> err
    job(0, 1, NB, 0, 0);           // solver silent -> timeout
    job(1, 0, NB, 20, 1);          // noise on requester 1 stream
    job(0, 1, NB + 4, 5, 0);       // overlong stream -> err
    job(1, 0, NB, 1030, 0);        // steps saturate at 1023
    for (int i = 0; i < 6; i++) begin
      r = $urandom_range(1, 3);
      job(r[0], r[1],
          ($urandom_range(0, 1) == 1) ? NB : $urandom_range(1, NB - 1),
          ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 60),
          1'($urandom_range(0, 1)));
    end
    reset_mid_solve();
    job(1, 1, NB, 9, 0);           // pointer back to requester 0
    job(1, 0, NB, 3, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("queues_empty", q_gnt.size() + q_min.size() + q_out0.size() + q_out1.size() + q_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
